// File: rtl/dot_product_sequencer.sv
// dot_product_sequencer
//
// Sequences the two-vector storage block for the keypad dot-product
// datapath. Keypad entries are steered into vector A and then vector B as
// single-cycle writes. A start request issues exactly N_ELEM back-to-back
// reads, multiply-accumulates the returned element pairs and holds the
// scalar result until the next run or reset.
//
// Ports:
//   CLK          clock, all logic on the rising edge
//   RST          synchronous active-high reset
//   keyValid     one-cycle strobe, keyData valid
//   keyData      keypad element value
//   start        one-cycle compute request
//   wrEn         storage write enable
//   selAB        storage write target, 0 = A, 1 = B
//   keyOut       storage write data
//   rdEn         storage read enable
//   readDataA    storage A read data (1-cycle latency)
//   readDataB    storage B read data (1-cycle latency)
//   result       dot product, held
//   resultValid  result valid (level)
//   busy         high while state = RUN
//   state        FSM state code for the display
//
// Build option:
//   DOTSEQ_SIGNED_EN  when defined, elements are two's complement and the
//                     product is sign-extended into the accumulator;
//                     otherwise all arithmetic is unsigned.

module dot_product_sequencer #(
    parameter int N_ELEM = 8,
    parameter int DATA_W = 8,
    parameter int ACC_W  = 2*DATA_W+3
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              keyValid,
    input  logic [DATA_W-1:0] keyData,
    input  logic              start,
    output logic              wrEn,
    output logic              selAB,
    output logic [DATA_W-1:0] keyOut,
    output logic              rdEn,
    input  logic [DATA_W-1:0] readDataA,
    input  logic [DATA_W-1:0] readDataB,
    output logic [ACC_W-1:0]  result,
    output logic              resultValid,
    output logic              busy,
    output logic [2:0]        state
);

    typedef enum logic [2:0] {
        LOAD_A = 3'd0,
        LOAD_B = 3'd1,
        READY  = 3'd2,
        RUN    = 3'd3,
        DONE   = 3'd4
    } seq_state_t;

    localparam int CNT_W = (N_ELEM > 1) ? $clog2(N_ELEM) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(N_ELEM - 1);

    seq_state_t cur_state;
    seq_state_t next_state;

    logic [CNT_W-1:0]    wr_cnt;
    logic [CNT_W-1:0]    rd_cnt;
    logic [CNT_W-1:0]    acc_cnt;
    logic                rd_valid;
    logic [ACC_W-1:0]    acc;
    logic [ACC_W-1:0]    product;
    logic [ACC_W-1:0]    acc_sum;
    logic [2*DATA_W-1:0] prod_full;
    logic                write_accept;
    logic                start_accept;
    logic                last_pair;

    // Operands are widened to the full product width before multiplying so
    // the multiply is computed at 2*DATA_W bits without truncation.
`ifdef DOTSEQ_SIGNED_EN
    assign prod_full = $signed({{DATA_W{readDataA[DATA_W-1]}}, readDataA})
                     * $signed({{DATA_W{readDataB[DATA_W-1]}}, readDataB});
    assign product   = {{(ACC_W-2*DATA_W){prod_full[2*DATA_W-1]}}, prod_full};
`else
    assign prod_full = {{DATA_W{1'b0}}, readDataA} * {{DATA_W{1'b0}}, readDataB};
    assign product   = {{(ACC_W-2*DATA_W){1'b0}}, prod_full};
`endif

    assign acc_sum = acc + product;

    always_comb begin
        write_accept = keyValid && ((cur_state == LOAD_A) || (cur_state == LOAD_B));
        start_accept = start && ((cur_state == READY) || (cur_state == DONE));
        // rd_valid marks the cycle a read issued one cycle earlier returns data.
        last_pair    = (cur_state == RUN) && rd_valid && (acc_cnt == LAST);
    end

    // State register.
    always_ff @(posedge CLK) begin
        if (RST) begin
            cur_state <= LOAD_A;
        end else begin
            cur_state <= next_state;
        end
    end

    // Next-state and state-derived outputs.
    always_comb begin
        next_state  = cur_state;
        busy        = 1'b0;
        resultValid = 1'b0;
        state       = cur_state;
        case (cur_state)
            LOAD_A: begin
                if (write_accept && (wr_cnt == LAST)) begin
                    next_state = LOAD_B;
                end
            end
            LOAD_B: begin
                if (write_accept && (wr_cnt == LAST)) begin
                    next_state = READY;
                end
            end
            READY: begin
                if (start) begin
                    next_state = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (last_pair) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                resultValid = 1'b1;
                if (start) begin
                    next_state = RUN;
                end
            end
            default: begin
                next_state = LOAD_A;
            end
        endcase
    end

    // Write steering, read issue and multiply-accumulate. wrEn, selAB and
    // keyOut are registered together, so the last A write still carries
    // selAB=0 in the cycle the state has already advanced to LOAD_B.
    always_ff @(posedge CLK) begin
        if (RST) begin
            wrEn     <= 1'b0;
            selAB    <= 1'b0;
            keyOut   <= '0;
            rdEn     <= 1'b0;
            rd_valid <= 1'b0;
            wr_cnt   <= '0;
            rd_cnt   <= '0;
            acc_cnt  <= '0;
            acc      <= '0;
            result   <= '0;
        end else begin
            wrEn     <= 1'b0;
            selAB    <= 1'b0;
            keyOut   <= '0;
            rd_valid <= rdEn;

            if (write_accept) begin
                wrEn   <= 1'b1;
                selAB  <= (cur_state == LOAD_B);
                keyOut <= keyData;
                wr_cnt <= (wr_cnt == LAST) ? '0 : wr_cnt + 1'b1;
            end

            if (start_accept) begin
                rdEn    <= 1'b1;
                rd_cnt  <= '0;
                acc_cnt <= '0;
                acc     <= '0;
            end else if (cur_state == RUN) begin
                if (rdEn) begin
                    rd_cnt <= rd_cnt + 1'b1;
                    rdEn   <= (rd_cnt != LAST);
                end
                if (rd_valid) begin
                    acc     <= acc_sum;
                    acc_cnt <= acc_cnt + 1'b1;
                    if (acc_cnt == LAST) begin
                        result <= acc_sum;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_dot_product_sequencer.sv
// tb_dot_product_sequencer
//
// Directed testbench for dot_product_sequencer. A small behavioural model
// of the two-vector storage block (sequential write pointers, registered
// reads with a wrapping read pointer) closes the loop around the DUT.

module tb_dot_product_sequencer;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        keyValid = 1'b0;
    logic [7:0]  keyData = 8'd0;
    logic        start = 1'b0;
    logic        wrEn;
    logic        selAB;
    logic [7:0]  keyOut;
    logic        rdEn;
    logic [7:0]  readDataA;
    logic [7:0]  readDataB;
    logic [18:0] result;
    logic        resultValid;
    logic        busy;
    logic [2:0]  state;

    int n_compared   = 0;
    int n_mismatched = 0;

    int mon_wr_a = 0;
    int mon_wr_b = 0;
    int mon_rd   = 0;

`ifdef DOTSEQ_SIGNED_EN
    localparam logic [18:0] EXP_FF02 = 19'h7FFF0;
`else
    localparam logic [18:0] EXP_FF02 = 19'd4080;
`endif

    dot_product_sequencer dut (
        .CLK         (CLK),
        .RST         (RST),
        .keyValid    (keyValid),
        .keyData     (keyData),
        .start       (start),
        .wrEn        (wrEn),
        .selAB       (selAB),
        .keyOut      (keyOut),
        .rdEn        (rdEn),
        .readDataA   (readDataA),
        .readDataB   (readDataB),
        .result      (result),
        .resultValid (resultValid),
        .busy        (busy),
        .state       (state)
    );

    always #5 CLK = ~CLK;

    // Storage block model.
    logic [7:0] memA [8];
    logic [7:0] memB [8];
    logic [2:0] wpA, wpB, rp;

    always @(posedge CLK) begin
        if (RST) begin
            wpA <= 3'd0;
            wpB <= 3'd0;
            rp  <= 3'd0;
            readDataA <= 8'd0;
            readDataB <= 8'd0;
        end else begin
            if (wrEn && !selAB) begin
                memA[wpA] <= keyOut;
                wpA <= wpA + 3'd1;
            end
            if (wrEn && selAB) begin
                memB[wpB] <= keyOut;
                wpB <= wpB + 3'd1;
            end
            if (rdEn) begin
                readDataA <= memA[rp];
                readDataB <= memB[rp];
                rp <= rp + 3'd1;
            end
        end
    end

    // Transaction counters sampled away from the active edge.
    always @(negedge CLK) begin
        if (wrEn && !selAB) mon_wr_a++;
        if (wrEn && selAB)  mon_wr_b++;
        if (rdEn)           mon_rd++;
    end

    task automatic send_key(input logic [7:0] v, input int gap);
        keyValid = 1'b1;
        keyData  = v;
        @(negedge CLK);
        keyValid = 1'b0;
        repeat (gap - 1) @(negedge CLK);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge CLK);
        start = 1'b0;
    endtask

    task automatic do_reset();
        RST = 1'b1;
        repeat (2) @(negedge CLK);
        RST = 1'b0;
    endtask

    // Pulses start and observes the following 14 cycles; j=0 is the first
    // cycle after the start edge.
    task automatic run_compute(output int n_rd, output int first_rd, output int last_rd,
                               output int valid_at, output logic valid0, output logic busy0);
        pulse_start();
        n_rd = 0; first_rd = -1; last_rd = -1; valid_at = -1;
        valid0 = resultValid;
        busy0  = busy;
        for (int j = 0; j < 14; j++) begin
            if (rdEn) begin
                n_rd++;
                if (first_rd < 0) first_rd = j;
                last_rd = j;
            end
            if (resultValid && valid_at < 0) valid_at = j;
            @(negedge CLK);
        end
    endtask

    task automatic test_reset();
        @(negedge CLK);
        do_reset();
        n_compared++; if (state !== 3'd0) begin n_mismatched++; $display("[TB] FAIL reset_state: got %0d expected 0", state); end
        n_compared++; if (wrEn !== 1'b0 || rdEn !== 1'b0 || selAB !== 1'b0) begin n_mismatched++; $display("[TB] FAIL reset_strobes: got wrEn=%b rdEn=%b selAB=%b expected 0 0 0", wrEn, rdEn, selAB); end
        n_compared++; if (keyOut !== 8'd0 || result !== 19'd0) begin n_mismatched++; $display("[TB] FAIL reset_data: got keyOut=%0d result=%0d expected 0 0", keyOut, result); end
        n_compared++; if (resultValid !== 1'b0 || busy !== 1'b0) begin n_mismatched++; $display("[TB] FAIL reset_flags: got resultValid=%b busy=%b expected 0 0", resultValid, busy); end
    endtask

    task automatic test_basic();
        int a0, b0, r0, n_rd, f_rd, l_rd, v_at;
        logic v0, b_0;
        a0 = mon_wr_a; b0 = mon_wr_b; r0 = mon_rd;
        for (int i = 1; i <= 8; i++) send_key(8'(i), 3);
        #1;
        n_compared++; if (mon_wr_a - a0 !== 8 || mon_wr_b - b0 !== 0) begin n_mismatched++; $display("[TB] FAIL basic_load_a: got A=%0d B=%0d writes expected 8 0", mon_wr_a - a0, mon_wr_b - b0); end
        n_compared++; if (state !== 3'd1) begin n_mismatched++; $display("[TB] FAIL basic_state_b: got %0d expected 1", state); end
        for (int i = 0; i < 8; i++) send_key(8'd1, 3);
        #1;
        n_compared++; if (mon_wr_a - a0 !== 8 || mon_wr_b - b0 !== 8) begin n_mismatched++; $display("[TB] FAIL basic_load_b: got A=%0d B=%0d writes expected 8 8", mon_wr_a - a0, mon_wr_b - b0); end
        n_compared++; if (state !== 3'd2 || mon_rd - r0 !== 0) begin n_mismatched++; $display("[TB] FAIL basic_ready: got state=%0d reads=%0d expected 2 0", state, mon_rd - r0); end
        run_compute(n_rd, f_rd, l_rd, v_at, v0, b_0);
        n_compared++; if (n_rd !== 8 || f_rd !== 0 || l_rd !== 7) begin n_mismatched++; $display("[TB] FAIL basic_rden: got n=%0d first=%0d last=%0d expected 8 0 7", n_rd, f_rd, l_rd); end
        n_compared++; if (b_0 !== 1'b1) begin n_mismatched++; $display("[TB] FAIL basic_busy: got %b expected 1", b_0); end
        n_compared++; if (v_at !== 9) begin n_mismatched++; $display("[TB] FAIL basic_valid_timing: got cycle %0d expected 9", v_at); end
        n_compared++; if (result !== 19'd36 || state !== 3'd4 || busy !== 1'b0) begin n_mismatched++; $display("[TB] FAIL basic_result: got result=%0d state=%0d busy=%b expected 36 4 0", result, state, busy); end
    endtask

    task automatic test_rerun();
        int n_rd, f_rd, l_rd, v_at;
        logic v0, b_0;
        run_compute(n_rd, f_rd, l_rd, v_at, v0, b_0);
        n_compared++; if (v0 !== 1'b0) begin n_mismatched++; $display("[TB] FAIL rerun_valid_drop: got %b expected 0", v0); end
        n_compared++; if (n_rd !== 8 || f_rd !== 0 || l_rd !== 7) begin n_mismatched++; $display("[TB] FAIL rerun_rden: got n=%0d first=%0d last=%0d expected 8 0 7", n_rd, f_rd, l_rd); end
        n_compared++; if (v_at !== 9 || result !== 19'd36) begin n_mismatched++; $display("[TB] FAIL rerun_result: got valid_at=%0d result=%0d expected 9 36", v_at, result); end
    endtask

    task automatic test_reset_abort();
        pulse_start();
        repeat (3) @(negedge CLK);
        n_compared++; if (rdEn !== 1'b1 || state !== 3'd3) begin n_mismatched++; $display("[TB] FAIL abort_in_run: got rdEn=%b state=%0d expected 1 3", rdEn, state); end
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        n_compared++; if (rdEn !== 1'b0 || state !== 3'd0 || busy !== 1'b0) begin n_mismatched++; $display("[TB] FAIL abort_ctrl: got rdEn=%b state=%0d busy=%b expected 0 0 0", rdEn, state, busy); end
        n_compared++; if (result !== 19'd0 || resultValid !== 1'b0) begin n_mismatched++; $display("[TB] FAIL abort_result: got result=%0d resultValid=%b expected 0 0", result, resultValid); end
        @(negedge CLK);
    endtask

    task automatic test_back_to_back();
        int good, n_rd, f_rd, l_rd, v_at;
        logic v0, b_0;
        good = 0;
        for (int i = 0; i < 16; i++) begin
            keyValid = 1'b1;
            keyData  = 8'd255;
            @(negedge CLK);
            if (wrEn === 1'b1 && selAB === (i >= 8) && keyOut === 8'd255) good++;
            if (i == 7) begin
                n_compared++; if (state !== 3'd1 || selAB !== 1'b0 || wrEn !== 1'b1) begin n_mismatched++; $display("[TB] FAIL b2b_last_a: got state=%0d selAB=%b wrEn=%b expected 1 0 1", state, selAB, wrEn); end
            end
        end
        keyValid = 1'b0;
        n_compared++; if (good !== 16) begin n_mismatched++; $display("[TB] FAIL b2b_writes: got %0d good write cycles expected 16", good); end
        n_compared++; if (state !== 3'd2) begin n_mismatched++; $display("[TB] FAIL b2b_ready: got %0d expected 2", state); end
        @(negedge CLK);
        n_compared++; if (wrEn !== 1'b0) begin n_mismatched++; $display("[TB] FAIL b2b_wr_stop: got %b expected 0", wrEn); end
        run_compute(n_rd, f_rd, l_rd, v_at, v0, b_0);
        n_compared++; if (result !== 19'd520200 || v_at !== 9 || n_rd !== 8) begin n_mismatched++; $display("[TB] FAIL b2b_result: got result=%0d valid_at=%0d reads=%0d expected 520200 9 8", result, v_at, n_rd); end
    endtask

    task automatic test_ignored_inputs();
        int r0, w0, n_rd, f_rd, l_rd, v_at;
        logic v0, b_0;
        do_reset();
        r0 = mon_rd;
        pulse_start();
        #1;
        n_compared++; if (state !== 3'd0 || rdEn !== 1'b0 || mon_rd - r0 !== 0) begin n_mismatched++; $display("[TB] FAIL ign_start_load_a: got state=%0d rdEn=%b reads=%0d expected 0 0 0", state, rdEn, mon_rd - r0); end
        for (int i = 0; i < 8; i++) send_key(8'hFF, 1);
        pulse_start();
        #1;
        n_compared++; if (state !== 3'd1 || rdEn !== 1'b0 || mon_rd - r0 !== 0) begin n_mismatched++; $display("[TB] FAIL ign_start_load_b: got state=%0d rdEn=%b reads=%0d expected 1 0 0", state, rdEn, mon_rd - r0); end
        for (int i = 0; i < 8; i++) send_key(8'h02, 1);
        @(negedge CLK);
        w0 = mon_wr_a + mon_wr_b;
        send_key(8'h55, 1);
        #1;
        n_compared++; if (state !== 3'd2 || wrEn !== 1'b0 || mon_wr_a + mon_wr_b - w0 !== 0) begin n_mismatched++; $display("[TB] FAIL ign_key_ready: got state=%0d wrEn=%b writes=%0d expected 2 0 0", state, wrEn, mon_wr_a + mon_wr_b - w0); end
        @(negedge CLK);
        run_compute(n_rd, f_rd, l_rd, v_at, v0, b_0);
        n_compared++; if (result !== EXP_FF02 || state !== 3'd4) begin n_mismatched++; $display("[TB] FAIL ff02_result: got result=%0h state=%0d expected %0h 4", result, state, EXP_FF02); end
        r0 = mon_rd;
        send_key(8'h77, 1);
        #1;
        n_compared++; if (state !== 3'd4 || wrEn !== 1'b0 || mon_wr_a + mon_wr_b - w0 !== 0) begin n_mismatched++; $display("[TB] FAIL ign_key_done: got state=%0d wrEn=%b writes=%0d expected 4 0 0", state, wrEn, mon_wr_a + mon_wr_b - w0); end
        n_compared++; if (resultValid !== 1'b1 || result !== EXP_FF02 || mon_rd - r0 !== 0) begin n_mismatched++; $display("[TB] FAIL ign_done_hold: got valid=%b result=%0h reads=%0d expected 1 %0h 0", resultValid, result, mon_rd - r0, EXP_FF02); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_rerun();
        test_reset_abort();
        test_back_to_back();
        test_ignored_inputs();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule

// File: doc/dot_product_sequencer.md
# dot_product_sequencer

Controller that sequences the two-vector storage block for the keypad dot-product datapath. It steers keypad entries into vector A, then vector B, as single-cycle writes. On a start request it issues exactly N_ELEM back-to-back reads, multiply-accumulates the returned element pairs, and holds the scalar result. It sits between the keypad front end and the storage block, and owns every WR_EN/RD_EN/selectAB transaction.

## Interface
- N_ELEM, 8, elements per vector; sets write and read counts.
- DATA_W, 8, element width.
- ACC_W, 2*DATA_W+3 (19), accumulator/result width; N_ELEM×(2^DATA_W−1)² must fit.
- CLK  in  1  clock; all logic on rising edge.
- RST  in  1  synchronous, active-high reset.
- keyValid  in  1  one-cycle strobe, keyData valid.
- keyData  in  DATA_W  keypad element value.
- start  in  1  one-cycle compute request.
- wrEn  out  1  storage write enable.
- selAB  out  1  storage target, 0 = A, 1 = B.
- keyOut  out  DATA_W  storage write data.
- rdEn  out  1  storage read enable.
- readDataA  in  DATA_W  storage A read data; registered, 1-cycle latency.
- readDataB  in  DATA_W  storage B read data; 1-cycle latency.
- result  out  ACC_W  dot product, held.
- resultValid  out  1  result valid, level.
- busy  out  1  high in RUN.
- state  out  3  FSM state code for the display.

## Operation
- States and codes: LOAD_A=0, LOAD_B=1, READY=2, RUN=3, DONE=4.
- Reset values: state=LOAD_A. wrEn, rdEn, selAB, keyOut, result, resultValid and busy all =0. Element counter and accumulator =0.
- LOAD_A: each keyValid produces one write (wrEn=1, selAB=0, keyOut=keyData) and increments the counter. After the N_ELEM-th write, the counter clears and the state moves to LOAD_B.
- LOAD_B: same as LOAD_A with selAB=1. After N_ELEM writes, the state moves to READY.
- READY: start moves the state to RUN. keyValid is ignored and produces no wrEn.
- RUN: rdEn is high for exactly N_ELEM consecutive cycles. Each returned pair is multiplied and added into the accumulator. After the last pair is accumulated, the state moves to DONE.
- DONE: result holds the final accumulator value and resultValid=1. A new start re-runs the computation on the same vectors; the storage read pointer wraps after N_ELEM reads. resultValid drops when RUN is entered. keyValid is ignored.
- start is ignored in LOAD_A, LOAD_B and RUN.
- Arithmetic: unsigned DATA_W×DATA_W product, zero-extended to ACC_W. The accumulator is cleared on entry to RUN. No saturation (widths guarantee no overflow).
- Reset mid-operation returns to LOAD_A from any state. A RUN burst is aborted with rdEn=0 on the next cycle. The storage block is not reset by this controller, so system reset must cover both blocks.
- doneA and doneB from storage are not used for sequencing; the controller's own counter is authoritative.

## Timing
- Writes: keyValid sampled at edge e drives wrEn, selAB and keyOut high for exactly the cycle after e; storage writes at edge e+1.
- Back-to-back keyValid on every cycle is supported (one write per cycle).
- The N_ELEM-th A write carries selAB=0 even though state=LOAD_B in that same cycle. selAB is registered together with wrEn.
- Read latency: with start sampled at edge t, rdEn is high during cycles t+1..t+N_ELEM.
- Data pairs are valid during cycles t+2..t+N_ELEM+1 and are accumulated at the end of each of those cycles.
- state=DONE and resultValid=1 from cycle t+N_ELEM+2. busy is high exactly while state=RUN.
- The storage block asserts doneA/doneB one cycle after the 8th write of each vector.

## Configuration
- DOTSEQ_SIGNED_EN defined: elements are two's complement, the product is signed, and the accumulator is sign-extended to ACC_W. result is signed.
- DOTSEQ_SIGNED_EN undefined: all arithmetic is unsigned, as described in Operation.

## Test plan
- Load A=1..8, B=1×8 via keyValid strobes 3 cycles apart, then start -> exactly 8 wrEn with selAB=0, then 8 with selAB=1. After start: 8 rdEn cycles, then result=36 and resultValid=1 at start edge +10.
- Load A=B=255×8 with back-to-back keyValid -> 16 consecutive wrEn cycles with selAB switching after the 8th. result=520200.
- start pulsed in LOAD_A and LOAD_B, and keyValid pulsed in READY and DONE -> no state change, no wrEn, no rdEn.
- Second start in DONE on the same vectors -> resultValid drops, 8 new rdEn cycles, identical result reappears.
- RST asserted on the 4th rdEn cycle of RUN -> next cycle rdEn=0, state=0, result=0, resultValid=0, busy=0.
- With DOTSEQ_SIGNED_EN: A=0xFF×8, B=0x02×8 -> result=−16 (19'h7FFF0). Without it: result=4080.
